// File: rtl/alu_cmd_issuer_pkg.sv
// rtl/alu_cmd_issuer_pkg.sv - shared types and constants for the ALU command issuer
package alu_cmd_issuer_pkg;

  localparam int ALU_OP_W  = 3;
  localparam int DEF_W     = 32;
  localparam int DEF_ZW    = 5;
  localparam int OVF_CNT_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } issuer_state_e;

  function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] v);
    return (&v) ? v : v + OVF_CNT_W'(1);
  endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// rtl/alu_rsp_fifo.sv - synchronous response FIFO holding {overflow, result} entries
module alu_rsp_fifo #(
  parameter int DW    = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [DW-1:0]            i_push_data,
  input  logic                     i_pop,
  output logic [DW-1:0]            o_head_data,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_full;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_valid   = (r_count != '0);
  assign o_count   = r_count;
  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop && o_valid;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Head is forced to zero when empty so the outputs read 0 out of reset.
  assign o_head_data = o_valid ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - issues one command at a time to the ALU and queues its results
module alu_cmd_issuer
  import alu_cmd_issuer_pkg::*;
#(
  parameter int W         = DEF_W,
  parameter int ZW        = DEF_ZW,
  parameter int ALU_LAT   = 1,
  parameter int RSP_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [W-1:0]         cmd_x,
  input  logic [W-1:0]         cmd_y,
  input  logic [ZW-1:0]        cmd_z,
  input  logic [ALU_OP_W-1:0]  cmd_op,
  output logic [W-1:0]         alu_x,
  output logic [W-1:0]         alu_y,
  output logic [ZW-1:0]        alu_z,
  output logic [ALU_OP_W-1:0]  alu_op,
  input  logic [W-1:0]         alu_result,
  input  logic                 alu_overflow,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [W-1:0]         rsp_result,
  output logic                 rsp_overflow,
  output logic                 busy,
  output logic [OVF_CNT_W-1:0] ovf_count
);

  localparam int LCW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam int CW  = $clog2(RSP_DEPTH) + 1;

  issuer_state_e         r_state;
  issuer_state_e         w_next_state;
  logic [LCW-1:0]        r_lat_cnt;
  logic [W-1:0]          r_alu_x;
  logic [W-1:0]          r_alu_y;
  logic [ZW-1:0]         r_alu_z;
  logic [ALU_OP_W-1:0]   r_alu_op;
  logic [OVF_CNT_W-1:0]  r_ovf_count;
  logic                  w_lat_done;
  logic                  w_accept;
  logic                  w_capture;
  logic                  w_cmd_ready;
  logic                  w_pop;
  logic [CW-1:0]         w_fifo_count;
  logic [W:0]            w_head;

  // Acceptance needs FIFO space so the eventual capture always has a slot.
  assign w_cmd_ready = (r_state == ST_IDLE) && (w_fifo_count < CW'(RSP_DEPTH));
  assign w_lat_done  = (r_lat_cnt == LCW'(ALU_LAT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid && w_cmd_ready) begin
          w_accept     = 1'b1;
          w_next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_lat_done) begin
          w_capture    = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lat_cnt <= '0;
    end else if (w_accept) begin
      r_lat_cnt <= '0;
    end else if (r_state == ST_WAIT && !w_lat_done) begin
      r_lat_cnt <= r_lat_cnt + LCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_x  <= '0;
      r_alu_y  <= '0;
      r_alu_z  <= '0;
      r_alu_op <= '0;
    end else if (w_accept) begin
      r_alu_x  <= cmd_x;
      r_alu_y  <= cmd_y;
      r_alu_z  <= cmd_z;
      r_alu_op <= cmd_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_count <= '0;
    end else if (w_capture && alu_overflow) begin
      r_ovf_count <= sat_inc(r_ovf_count);
    end
  end

  assign w_pop = rsp_valid && rsp_ready;

  alu_rsp_fifo #(
    .DW    (W + 1),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_capture),
    .i_push_data ({alu_overflow, alu_result}),
    .i_pop       (w_pop),
    .o_head_data (w_head),
    .o_valid     (rsp_valid),
    .o_count     (w_fifo_count)
  );

  assign cmd_ready    = w_cmd_ready;
  assign alu_x        = r_alu_x;
  assign alu_y        = r_alu_y;
  assign alu_z        = r_alu_z;
  assign alu_op       = r_alu_op;
  assign rsp_result   = w_head[W-1:0];
  assign rsp_overflow = w_head[W];
  assign busy         = (r_state != ST_IDLE);
  assign ovf_count    = r_ovf_count;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - self-checking bench for alu_cmd_issuer with a stub adder ALU
module tb_alu_cmd_issuer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_x = '0;
  logic [31:0] cmd_y = '0;
  logic [4:0]  cmd_z = '0;
  logic [2:0]  cmd_op = '0;
  logic [31:0] alu_x, alu_y, alu_result;
  logic [4:0]  alu_z;
  logic [2:0]  alu_op;
  logic        alu_overflow;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_overflow;
  logic        busy;
  logic [15:0] ovf_count;

  int checks = 0;
  int errors = 0;
  logic [32:0] sb[$];

  always #5 clk = ~clk;

  alu_cmd_issuer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_z(cmd_z), .cmd_op(cmd_op),
    .alu_x(alu_x), .alu_y(alu_y), .alu_z(alu_z), .alu_op(alu_op),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
    .busy(busy), .ovf_count(ovf_count)
  );

  // Stub ALU: op 000 is a signed add with overflow, anything else is XOR.
  function automatic logic [32:0] ref_alu(input logic [31:0] x, input logic [31:0] y,
                                          input logic [2:0] op);
    logic [31:0] s;
    if (op == 3'b000) begin
      s = x + y;
      return {(x[31] == y[31]) && (s[31] != x[31]), s};
    end
    return {1'b0, x ^ y};
  endfunction

  assign {alu_overflow, alu_result} = ref_alu(alu_x, alu_y, alu_op);

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  z;
    logic [2:0]  op;
    logic [31:0] exp_result;
    logic        exp_ovf;
  } vec_t;

  vec_t tab[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge: scores the pop and accept about to happen, then advances one cycle.
  task automatic tick(input bit use_exp, input logic [32:0] exp_in);
    logic acc;
    logic pop;
    logic [32:0] e;
    acc = cmd_valid && cmd_ready;
    pop = rsp_valid && rsp_ready;
    if (pop) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got %0h expected none", {rsp_overflow, rsp_result});
      end else begin
        e = sb.pop_front();
        chk("rsp_data", {31'b0, rsp_overflow, rsp_result}, {31'b0, e});
      end
    end
    if (acc) sb.push_back(use_exp ? exp_in : ref_alu(cmd_x, cmd_y, cmd_op));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [4:0] z,
                       input logic [2:0] op, input bit use_exp, input logic [32:0] exp_v);
    bit done;
    done = 1'b0;
    cmd_x = x; cmd_y = y; cmd_z = z; cmd_op = op;
    cmd_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (cmd_ready) done = 1'b1;
      tick(use_exp, exp_v);
    end
    cmd_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got cmd_ready 0 expected 1 within 40 cycles");
    end
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int i = 0; i < 40 && (sb.size() != 0 || busy); i++) tick(1'b0, '0);
    chk("drain_sb_empty", 64'(sb.size()), 64'd0);
    chk("drain_rsp_valid", 64'(rsp_valid), 64'd0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [32:0] hold_head;
    bit          fifth_done;

    tab[0] = '{32'h00000001, 32'h00000002, 5'd0,  3'b000, 32'h00000003, 1'b0};
    tab[1] = '{32'h80000000, 32'h80000000, 5'd1,  3'b000, 32'h00000000, 1'b1};
    tab[2] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 5'd2,  3'b000, 32'hFFFFFFFE, 1'b1};
    tab[3] = '{32'h12345678, 32'h11111111, 5'd3,  3'b000, 32'h23456789, 1'b0};
    tab[4] = '{32'hF0F0F0F0, 32'h0FF00FF0, 5'd31, 3'b011, 32'hFF00FF00, 1'b0};
    tab[5] = '{32'hFFFFFFFF, 32'h00000001, 5'd4,  3'b000, 32'h00000000, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_result", 64'({rsp_overflow, rsp_result}), 64'd0);
    chk("rst_alu_x", 64'(alu_x), 64'd0);
    chk("rst_ovf_count", 64'(ovf_count), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single command latency: response valid two edges after the accept request.
    cmd_x = 32'hFFFFFFFF; cmd_y = 32'hFFFFFFFF; cmd_z = 5'b10000; cmd_op = 3'b000;
    cmd_valid = 1'b1;
    chk("lat_cmd_ready", 64'(cmd_ready), 64'd1);
    tick(1'b1, {1'b0, 32'hFFFFFFFE});
    cmd_valid = 1'b0;
    chk("lat_busy", 64'(busy), 64'd1);
    chk("lat_rsp_valid_early", 64'(rsp_valid), 64'd0);
    chk("lat_alu_x", 64'(alu_x), 64'hFFFFFFFF);
    chk("lat_alu_z", 64'(alu_z), 64'h10);
    tick(1'b0, '0);
    chk("lat_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("lat_rsp_result", 64'(rsp_result), 64'hFFFFFFFE);
    chk("lat_rsp_ovf", 64'(rsp_overflow), 64'd0);
    chk("lat_busy_done", 64'(busy), 64'd0);
    drain();

    issue(32'h7FFFFFFF, 32'h00000001, 5'd0, 3'b000, 1'b1, {1'b1, 32'h80000000});
    drain();
    chk("ovf_count_1", 64'(ovf_count), 64'd1);

    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++)
      issue(tab[i].x, tab[i].y, tab[i].z, tab[i].op, 1'b1, {tab[i].exp_ovf, tab[i].exp_result});
    drain();
    chk("ovf_count_3", 64'(ovf_count), 64'd3);

    // FIFO full: four accepted, fifth held off until the consumer drains.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue($urandom, $urandom, 5'(i), 3'(i % 2), 1'b0, '0);
    tick(1'b0, '0);
    chk("full_rsp_valid", 64'(rsp_valid), 64'd1);
    cmd_x = 32'hCAFE0000; cmd_y = 32'h0000BEEF; cmd_z = 5'd9; cmd_op = 3'b000;
    cmd_valid = 1'b1;
    hold_head = sb[0];
    for (int i = 0; i < 3; i++) begin
      chk("full_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("full_head_hold", 64'({rsp_overflow, rsp_result}), 64'(hold_head));
      tick(1'b0, '0);
    end
    rsp_ready = 1'b1;
    fifth_done = 1'b0;
    for (int i = 0; i < 20 && !fifth_done; i++) begin
      if (cmd_ready) fifth_done = 1'b1;
      tick(1'b0, '0);
    end
    cmd_valid = 1'b0;
    chk("fifth_accepted", 64'(fifth_done), 64'd1);
    drain();

    // Capture and pop on the same edge with three entries queued.
    for (int i = 0; i < 3; i++) issue($urandom, $urandom, 5'd0, 3'b000, 1'b0, '0);
    tick(1'b0, '0);
    issue(32'h00000100, 32'h00000200, 5'd0, 3'b000, 1'b1, {1'b0, 32'h00000300});
    rsp_ready = 1'b1;
    tick(1'b0, '0);
    rsp_ready = 1'b0;
    chk("simul_cmd_ready", 64'(cmd_ready), 64'd1);
    hold_head = sb[0];
    chk("simul_head", 64'({rsp_overflow, rsp_result}), 64'(hold_head));
    tick(1'b0, '0);
    chk("simul_head_stable", 64'({rsp_overflow, rsp_result}), 64'(hold_head));
    issue(32'h00000005, 32'h00000006, 5'd0, 3'b000, 1'b1, {1'b0, 32'h0000000B});
    tick(1'b0, '0);
    chk("simul_full", 64'(cmd_ready), 64'd0);
    drain();

    // Reset while a command is in flight discards it.
    issue(32'h7FFFFFFF, 32'h00000001, 5'd0, 3'b000, 1'b0, '0);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("rstw_busy", 64'(busy), 64'd0);
    chk("rstw_alu_x", 64'(alu_x), 64'd0);
    chk("rstw_ovf_count", 64'(ovf_count), 64'd0);
    chk("rstw_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b0, '0);
    chk("rstw_no_rsp", 64'(rsp_valid), 64'd0);
    chk("rstw_ovf_after", 64'(ovf_count), 64'd0);
    rsp_ready = 1'b0;

    force dut.r_ovf_count = 16'hFFFE;
    #1;
    release dut.r_ovf_count;
    for (int i = 0; i < 3; i++) begin
      issue(32'h7FFFFFFF, 32'h00000001, 5'd0, 3'b000, 1'b1, {1'b1, 32'h80000000});
      drain();
      chk("sat_ovf_count", 64'(ovf_count), 64'hFFFF);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
